// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared encodings and MISR step for the stimulus pattern generator
package stim_pkg;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_WALK = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic [15:0] data);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ data;
  endfunction

endpackage

// File: rtl/misr16.sv
// rtl/misr16.sv - 16-bit multiple-input signature register with clear and enable
module misr16
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= 16'h0000;
    end else if (en) begin
      sig <= misr_step(sig, data);
    end
  end

endmodule

// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - exhaustive binary/Gray/walking-one stimulus sweep generator
// Optional response signature compaction enabled by macro RESP_SIG_EN.
module stim_pattern_gen
  import stim_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 10,
  parameter int RESP_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  pattern,
  output logic              vec_valid,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sig
);

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HCW      = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_EFF - 1);
  localparam logic [WIDTH:0] LAST_BIN  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] LAST_WALK = (WIDTH + 1)'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   idx_q;
  logic [HCW-1:0]   hold_q;
  logic [WIDTH-1:0] pattern_q;
  logic             start_acc;
  logic             hold_end;
  logic             last_vec;

  function automatic logic [WIDTH-1:0] vec_at(input logic [WIDTH:0] k, input logic [1:0] m);
    logic [WIDTH-1:0] kb;
    kb = k[WIDTH-1:0];
    case (m)
      MODE_GRAY: return kb ^ (kb >> 1);
      MODE_WALK: return WIDTH'(1) << k;
      default:   return kb;
    endcase
  endfunction

  assign hold_end = (state_q == RUN) && (hold_q == HOLD_LAST);
  assign last_vec = (mode_q == MODE_WALK) ? (idx_q == LAST_WALK) : (idx_q == LAST_BIN);
  assign pattern  = pattern_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    busy      = 1'b0;
    vec_valid = 1'b0;
    done      = 1'b0;
    sample    = hold_end;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        vec_valid = 1'b1;
        if (hold_end && last_vec) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pattern is computed one edge ahead so it only ever changes right after a sample pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= 2'd0;
      idx_q     <= '0;
      hold_q    <= '0;
      pattern_q <= '0;
    end else if (start_acc) begin
      mode_q    <= mode;
      idx_q     <= '0;
      hold_q    <= '0;
      pattern_q <= vec_at('0, mode);
    end else if (state_q == RUN) begin
      if (hold_end) begin
        hold_q <= '0;
        if (last_vec) begin
          pattern_q <= '0;
        end else begin
          idx_q     <= idx_q + 1'b1;
          pattern_q <= vec_at(idx_q + 1'b1, mode_q);
        end
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end else begin
      pattern_q <= '0;
    end
  end

`ifdef RESP_SIG_EN
  misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (sample),
    .data  (16'(resp)),
    .sig   (sig)
  );
`else
  logic unused_resp;
  assign unused_resp = ^resp;
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_stim_pattern_gen.sv
// tb/tb_stim_pattern_gen.sv - randomized self-checking bench for stim_pattern_gen
module tb_stim_pattern_gen;

  localparam int WIDTH  = 3;
  localparam int HOLD   = 2;
  localparam int RESP_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic [RESP_W-1:0] resp;
  logic [WIDTH-1:0]  pattern;
  logic              vec_valid;
  logic              sample;
  logic              busy;
  logic              done;
  logic [15:0]       sig;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_sig;

  stim_pattern_gen #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .RESP_W(RESP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .resp      (resp),
    .pattern   (pattern),
    .vec_valid (vec_valid),
    .sample    (sample),
    .busy      (busy),
    .done      (done),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] shifted;
    shifted = s << 1;
    return shifted ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".pattern"}, 32'(pattern), 32'd0);
    check({tag, ".vec_valid"}, 32'(vec_valid), 32'd0);
    check({tag, ".sample"}, 32'(sample), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".sig"}, 32'(sig), 32'(model_sig));
  endtask

  // Expected per-cycle pattern list built straight from the sweep rules
  task automatic build_seq(input logic [1:0] m, output int seq[$]);
    int n;
    int v;
    seq = {};
    n = (m == 2'd2) ? WIDTH : (1 << WIDTH);
    for (int k = 0; k < n; k++) begin
      if (m == 2'd1)      v = k ^ (k >> 1);
      else if (m == 2'd2) v = 1 << k;
      else                v = k;
      for (int h = 0; h < HOLD; h++) seq.push_back(v);
    end
  endtask

  task automatic run_run_cycles(input int seq[$], input int upto);
    for (int i = 0; i < upto; i++) begin
      bit es;
      es = ((i % HOLD) == HOLD - 1);
      check("run.pattern", 32'(pattern), 32'(seq[i]));
      check("run.vec_valid", 32'(vec_valid), 32'd1);
      check("run.busy", 32'(busy), 32'd1);
      check("run.done", 32'(done), 32'd0);
      check("run.sample", 32'(sample), 32'(es));
      check("run.sig", 32'(sig), 32'(model_sig));
      start = 1'($urandom_range(0, 1));
      mode  = 2'($urandom);
      resp  = RESP_W'($urandom);
`ifdef RESP_SIG_EN
      if (es) model_sig = ref_misr(model_sig, 16'(resp));
`endif
      step();
    end
  endtask

  task automatic run_sweep(input logic [1:0] m, input bit keep_start);
    int seq[$];
    build_seq(m, seq);
    check_idle("idle");
    start = 1'b1;
    mode  = m;
    step();
    model_sig = 16'h0000;
    run_run_cycles(seq, seq.size());
    check("done.done", 32'(done), 32'd1);
    check("done.busy", 32'(busy), 32'd0);
    check("done.vec_valid", 32'(vec_valid), 32'd0);
    check("done.pattern", 32'(pattern), 32'd0);
    check("done.sample", 32'(sample), 32'd0);
    check("done.sig", 32'(sig), 32'(model_sig));
    start = keep_start;
    mode  = 2'($urandom);
    step();
  endtask

  initial begin
    int seq[$];
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    resp      = '0;
    model_sig = 16'h0000;
    step();
    step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    run_sweep(2'd0, 1'b0);
    run_sweep(2'd1, 1'b0);
    run_sweep(2'd2, 1'b1);
    run_sweep(2'd0, 1'b0);
    run_sweep(2'd3, 1'b0);

    // abandon a binary sweep with a reset during cycle 5
    check_idle("pre_rst");
    build_seq(2'd0, seq);
    start = 1'b1;
    mode  = 2'd0;
    step();
    model_sig = 16'h0000;
    run_run_cycles(seq, 4);
    rst_n = 1'b0;
    step();
    model_sig = 16'h0000;
    check_idle("mid_rst");
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check_idle("post_rst");
    step();
    check_idle("post_rst2");

    for (int r = 0; r < 8; r++) begin
      run_sweep(2'($urandom), (r < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    check_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stim_pattern_gen.md
Name: stim_pattern_gen

Overview:
Synthesizable, parametrised exhaustive-stimulus generator for small combinational blocks.
- Drives a WIDTH-bit input vector through a full sweep in binary, Gray or walking-one order.
- Holds each vector for a programmable number of cycles and samples the DUT response on the last hold cycle.
- Sits between a control FSM or test harness and the block under test, so the same sweep runs on-board and in simulation.

Parameters:
WIDTH, 3, number of stimulus bits driven to the block under test (1..16)
HOLD_CYCLES, 10, clock cycles each vector is held; a value of 0 is treated as 1
RESP_W, 2, width of the response bus sampled from the block under test (1..16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
mode  input  2  sweep order, latched at start: 0 binary, 1 Gray, 2 walking-one, 3 treated as binary
resp  input  RESP_W  response from the block under test
pattern  output  WIDTH  stimulus vector; bit 0 toggles fastest
vec_valid  output  1  high while pattern holds a sweep vector
sample  output  1  one-cycle pulse on the last hold cycle of each vector
busy  output  1  high in RUN
done  output  1  one-cycle pulse after the final vector
sig  output  16  response signature (see Optional Feature)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; pattern, vec_valid, sample, busy, done and sig all 0.
- Reset wins over every other event, including mid-sweep. A mid-sweep reset abandons the sweep and does not pulse done.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: when start=1. In the same edge:
  - latch mode;
  - clear the index counter (WIDTH+1 bits) and the hold counter;
  - clear sig.
- The first cycle in RUN presents vector 0 with vec_valid=1 and busy=1. Latency from the start edge to the first vector is 1 cycle.
- Vector count N:
  - binary and Gray: N = 2^WIDTH;
  - walking-one: N = WIDTH.
- Vector k mapping:
  - binary: k;
  - Gray: k ^ (k>>1);
  - walking-one: 1<<k.
- Hold counter:
  - counts 0..HOLD_CYCLES-1;
  - sample=1 when it equals HOLD_CYCLES-1;
  - on that cycle the index increments and the hold counter wraps to 0.
- Sample cycle with index = N-1: next state DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, vec_valid=0;
  - pattern returns to 0;
  - next state IDLE.
- start is ignored outside IDLE. start held high continuously re-arms a new sweep on the cycle after DONE.
- A mode change during RUN has no effect.
- pattern is registered and glitch-free. Vector transitions occur only on the clk edge after a sample pulse.
- WIDTH=16 with binary mode sweeps 65536 vectors. The index counter must not overflow (WIDTH+1 bits).

Optional Feature:
Macro RESP_SIG_EN.
- Defined: a 16-bit MISR compacts resp on every sample pulse:
  - sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ zero-extended resp;
  - sig is cleared at start acceptance and holds its value after done until the next start.
- Not defined: sig is tied to 16'h0000, resp is unused, and no MISR logic is synthesized.

Decomposition:
- Package stim_pkg contains:
  - mode encodings (MODE_BIN=0, MODE_GRAY=1, MODE_WALK=2);
  - FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits);
  - the MISR polynomial constant 16'h1021.
- Sub-module misr16: a 16-bit MISR with enable, clear and a 16-bit data input. It is instantiated only under RESP_SIG_EN.

Test Plan:
- Binary sweep, WIDTH=3, HOLD_CYCLES=2, mode=0, start pulsed at cycle 0:
  - pattern = 0,0,1,1,…,7,7 on cycles 1-16;
  - sample on even cycles 2..16;
  - done=1 on cycle 17;
  - busy low from cycle 17.
- Gray sweep, WIDTH=3, HOLD_CYCLES=1, mode=1 -> pattern 0,1,3,2,6,7,5,4 on cycles 1-8, done on cycle 9.
- Walking-one sweep, WIDTH=3, HOLD_CYCLES=2, mode=2 -> pattern 1,1,2,2,4,4, then done on cycle 7.
- Reset mid-run: rst_n low at cycle 5 of a binary sweep -> next cycle all outputs 0, state IDLE, no done pulse; a new start restarts from vector 0.
- start re-asserted during RUN and mode changed to 2 mid-sweep -> sweep continues unchanged in binary order to completion.
- RESP_SIG_EN defined, WIDTH=3, HOLD_CYCLES=1, mode=0, resp=pattern[1:0] -> sig after done equals the value computed by the reference MISR model; not defined -> sig stays 16'h0000.
